// File: rtl/fpu_mul_pipe_if.sv
// Operand/result handshake bundle for fpu_mul_pipe.
// The flags field exists only when FPU_MUL_FLAGS_EN is defined.
interface fpu_mul_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   rmode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] z;
`ifdef FPU_MUL_FLAGS_EN
  logic [3:0]   flags;
`endif

  modport master (
    output in_valid, a, b, rmode, out_ready,
    input  in_ready, out_valid, z
`ifdef FPU_MUL_FLAGS_EN
    , input flags
`endif
  );

  modport slave (
    input  in_valid, a, b, rmode, out_ready,
    output in_ready, out_valid, z
`ifdef FPU_MUL_FLAGS_EN
    , output flags
`endif
  );
endinterface

// File: rtl/fpu_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready flow control.
// Define FPU_MUL_FLAGS_EN to add the {NV,OF,UF,NX} flags output.
module fpu_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic           clk_i,
  input logic           rst_i,
  fpu_mul_pipe_if.slave mul_io
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * (MAN_W + 1);
  localparam int XW = EXP_W + 2;
  localparam logic [XW-1:0] BIAS_X  = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic [XW-1:0] EXP_TOP = {2'b00, {EXP_W{1'b1}}};

  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
  } cls_t;

  function automatic cls_t classify(input logic [W-1:0] x);
    cls_t c;
    c.zero = (x[W-2 -: EXP_W] == {EXP_W{1'b0}});
    c.inf  = (x[W-2 -: EXP_W] == {EXP_W{1'b1}}) && (x[MAN_W-1:0] == {MAN_W{1'b0}});
    c.nan  = (x[W-2 -: EXP_W] == {EXP_W{1'b1}}) && (x[MAN_W-1:0] != {MAN_W{1'b0}});
    return c;
  endfunction

  logic          v1_q, v2_q, v3_q, v1_d, v2_d, v3_d;
  logic          rdy1_s, rdy2_s, rdy3_s;
  logic [W-1:0]  a1_q, b1_q;
  logic [1:0]    rm1_q, rm2_q;
  cls_t          ca1_q, cb1_q;
  logic          sign2_q, nan2_q, inf2_q, zero2_q;
  logic [XW-1:0] exp2_q;
  logic [PW-1:0] prod2_q;
  logic [PW-2:0] norm_s;
  logic [XW-1:0] exp_n_s, exp_f_s;
  logic [MAN_W:0] man_r_s;
  logic          guard_s, sticky_s, inexact_s, inc_s, to_inf_s, ovf_s, udf_s;
  logic [W-1:0]  z_d, z_q;

  assign rdy3_s = !v3_q || mul_io.out_ready;
  assign rdy2_s = !v2_q || rdy3_s;
  assign rdy1_s = !v1_q || rdy2_s;

  assign mul_io.in_ready  = rdy1_s && !rst_i;
  assign mul_io.out_valid = v3_q;
  assign mul_io.z         = z_q;

  // Stage valid bits advance wherever the downstream slot is free.
  always_comb begin
    v1_d = rdy1_s ? mul_io.in_valid : v1_q;
    v2_d = rdy2_s ? v1_q : v2_q;
    v3_d = rdy3_s ? v2_q : v3_q;
  end

  // Stage 1: capture operands and their classification.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1_q  <= 1'b0;
      a1_q  <= {W{1'b0}};
      b1_q  <= {W{1'b0}};
      rm1_q <= 2'b00;
      ca1_q <= 3'b000;
      cb1_q <= 3'b000;
    end else begin
      v1_q <= v1_d;
      if (rdy1_s && mul_io.in_valid) begin
        a1_q  <= mul_io.a;
        b1_q  <= mul_io.b;
        rm1_q <= mul_io.rmode;
        ca1_q <= classify(mul_io.a);
        cb1_q <= classify(mul_io.b);
      end
    end
  end

  // Stage 2: sign, biased exponent sum and full significand product.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v2_q    <= 1'b0;
      sign2_q <= 1'b0;
      exp2_q  <= {XW{1'b0}};
      prod2_q <= {PW{1'b0}};
      nan2_q  <= 1'b0;
      inf2_q  <= 1'b0;
      zero2_q <= 1'b0;
      rm2_q   <= 2'b00;
    end else begin
      v2_q <= v2_d;
      if (rdy2_s && v1_q) begin
        sign2_q <= a1_q[W-1] ^ b1_q[W-1];
        exp2_q  <= {2'b00, a1_q[W-2 -: EXP_W]} + {2'b00, b1_q[W-2 -: EXP_W]} - BIAS_X;
        prod2_q <= {{(MAN_W+1){1'b0}}, 1'b1, a1_q[MAN_W-1:0]} *
                   {{(MAN_W+1){1'b0}}, 1'b1, b1_q[MAN_W-1:0]};
        nan2_q  <= ca1_q.nan || cb1_q.nan || (ca1_q.inf && cb1_q.zero) || (cb1_q.inf && ca1_q.zero);
        inf2_q  <= ca1_q.inf || cb1_q.inf;
        zero2_q <= ca1_q.zero || cb1_q.zero;
        rm2_q   <= rm1_q;
      end
    end
  end

  // Stage 3 datapath: normalise, round, then resolve specials and range.
  always_comb begin
    norm_s    = prod2_q[PW-1] ? prod2_q[PW-2:0] : {prod2_q[PW-3:0], 1'b0};
    exp_n_s   = exp2_q + {{(XW-1){1'b0}}, prod2_q[PW-1]};
    guard_s   = norm_s[MAN_W];
    sticky_s  = |norm_s[MAN_W-1:0];
    inexact_s = guard_s | sticky_s;
    case (rm2_q)
      2'd0:    inc_s = guard_s & (sticky_s | norm_s[MAN_W+1]);
      2'd1:    inc_s = 1'b0;
      2'd2:    inc_s = inexact_s & ~sign2_q;
      2'd3:    inc_s = inexact_s & sign2_q;
      default: inc_s = 1'b0;
    endcase
    case (rm2_q)
      2'd0:    to_inf_s = 1'b1;
      2'd1:    to_inf_s = 1'b0;
      2'd2:    to_inf_s = ~sign2_q;
      2'd3:    to_inf_s = sign2_q;
      default: to_inf_s = 1'b0;
    endcase
    // A carry out of the stored field means the significand became 10.000..: field is zero, exponent bumps.
    man_r_s = {1'b0, norm_s[PW-2 -: MAN_W]} + {{MAN_W{1'b0}}, inc_s};
    exp_f_s = exp_n_s + {{(XW-1){1'b0}}, man_r_s[MAN_W]};
    ovf_s   = ($signed(exp_f_s) >= $signed(EXP_TOP));
    udf_s   = exp_f_s[XW-1] || (exp_f_s == {XW{1'b0}});
    if (nan2_q) begin
      z_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    end else if (inf2_q) begin
      z_d = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (zero2_q) begin
      z_d = {sign2_q, {(W-1){1'b0}}};
    end else if (ovf_s) begin
      if (to_inf_s) begin
        z_d = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else begin
        z_d = {sign2_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      end
    end else if (udf_s) begin
      z_d = {sign2_q, {(W-1){1'b0}}};
    end else begin
      z_d = {sign2_q, exp_f_s[EXP_W-1:0], man_r_s[MAN_W-1:0]};
    end
  end

  // Stage 3 register: result held stable while the consumer stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v3_q <= 1'b0;
      z_q  <= {W{1'b0}};
    end else begin
      v3_q <= v3_d;
      if (rdy3_s && v2_q) begin
        z_q <= z_d;
      end
    end
  end

`ifdef FPU_MUL_FLAGS_EN
  logic [3:0] flags_d, flags_q;

  // Exception flags {NV,OF,UF,NX}; specials other than NaN raise nothing.
  always_comb begin
    flags_d = 4'b0000;
    if (nan2_q) begin
      flags_d = 4'b1000;
    end else if (inf2_q || zero2_q) begin
      flags_d = 4'b0000;
    end else if (ovf_s) begin
      flags_d = 4'b0101;
    end else if (udf_s) begin
      flags_d = 4'b0011;
    end else begin
      flags_d = {3'b000, inexact_s};
    end
  end

  // Flags travel with the result under the same enable.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      flags_q <= 4'b0000;
    end else if (rdy3_s && v2_q) begin
      flags_q <= flags_d;
    end
  end

  assign mul_io.flags = flags_q;
`endif
endmodule

// File: tb/tb_fpu_mul_pipe.sv
// Self-checking bench for fpu_mul_pipe: directed vectors, stall/drain, mid-flight reset
// and randomized traffic scored against an arithmetic reference model.
module tb_fpu_mul_pipe;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [35:0] exp_q[$];
  logic [35:0] mon_item;

  fpu_mul_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) mif ();

  fpu_mul_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .mul_io (mif.slave)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] req);
    n_cmp++;
    if (obs !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, req);
    end
  endtask

  // Reference: exact integer significand product, rounded by comparing the remainder to one half.
  function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm);
    int     ea, eb, e, sh;
    longint ma, mb, p, q, rem, half;
    bit     s, inx, up, to_inf, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic [31:0] z;
    logic [3:0]  f;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    nan_a  = (ea == 255) && (a[22:0] != 23'd0);
    nan_b  = (eb == 255) && (b[22:0] != 23'd0);
    inf_a  = (ea == 255) && (a[22:0] == 23'd0);
    inf_b  = (eb == 255) && (b[22:0] == 23'd0);
    zero_a = (ea == 0);
    zero_b = (eb == 0);
    if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) return {4'b1000, 32'h7FC00000};
    if (inf_a || inf_b) return {4'b0000, s, 8'hFF, 23'd0};
    if (zero_a || zero_b) return {4'b0000, s, 31'd0};
    ma = longint'({1'b1, a[22:0]});
    mb = longint'({1'b1, b[22:0]});
    p  = ma * mb;
    e  = ea + eb - 127;
    if (p >= (longint'(1) << 47)) begin
      sh = 24;
      e++;
    end else begin
      sh = 23;
    end
    q    = p >> sh;
    rem  = p - (q << sh);
    half = longint'(1) << (sh - 1);
    inx  = (rem != 0);
    case (rm)
      2'd0:    up = (rem > half) || ((rem == half) && q[0]);
      2'd2:    up = inx && !s;
      2'd3:    up = inx && s;
      default: up = 1'b0;
    endcase
    q = q + longint'(up);
    if (q == (longint'(1) << 24)) begin
      q = q >> 1;
      e++;
    end
    to_inf = (rm == 2'd0) || ((rm == 2'd2) && !s) || ((rm == 2'd3) && s);
    if (e >= 255) begin
      z = to_inf ? {s, 8'hFF, 23'd0} : {s, 8'hFE, 23'h7FFFFF};
      f = 4'b0101;
    end else if (e <= 0) begin
      z = {s, 31'd0};
      f = 4'b0011;
    end else begin
      z = {s, e[7:0], q[22:0]};
      f = {3'b000, inx};
    end
    return {f, z};
  endfunction

  function automatic logic [31:0] rand_fp();
    int cat;
    logic [7:0]  e;
    logic [22:0] m;
    cat = $urandom_range(0, 15);
    m   = 23'($urandom);
    case (cat)
      0:       e = 8'd0;
      1:       begin e = 8'hFF; m = 23'd0; end
      2:       begin e = 8'hFF; m = m | 23'd1; end
      3:       e = 8'($urandom_range(1, 40));
      4, 5:    e = 8'($urandom_range(180, 254));
      6:       begin e = 8'($urandom_range(110, 140)); m = m & 23'h7FFF00; end
      default: e = 8'($urandom_range(90, 165));
    endcase
    return {1'($urandom), e, m};
  endfunction

  // Scoreboard: one reference result per accepted pair, retired in order.
  always @(negedge clk) begin
    if (!rst) begin
      if (mif.out_valid && mif.out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("sb_unexpected_out", 64'd1, 64'd0);
        end else begin
          mon_item = exp_q.pop_front();
          check_val("sb_z", mif.z, mon_item[31:0]);
`ifdef FPU_MUL_FLAGS_EN
          check_val("sb_flags", mif.flags, mon_item[35:32]);
`endif
        end
      end
      if (mif.in_valid && mif.in_ready) exp_q.push_back(ref_mul(mif.a, mif.b, mif.rmode));
    end
  end

  task automatic send_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                         input logic [31:0] zx, input logic [3:0] fx);
    int k;
    @(posedge clk); #1;
    mif.a = a; mif.b = b; mif.rmode = rm;
    mif.in_valid = 1'b1; mif.out_ready = 1'b1;
    @(posedge clk); #1;
    mif.in_valid = 1'b0;
    k = 1;
    while (!mif.out_valid && k < 12) begin
      @(posedge clk); #1;
      k++;
    end
    check_val("dir_latency", k, 3);
    check_val("dir_z", mif.z, zx);
`ifdef FPU_MUL_FLAGS_EN
    check_val("dir_flags", mif.flags, fx);
`else
    if (fx === 4'bxxxx) check_val("dir_flags_unused", 64'd0, 64'd1);
`endif
  endtask

  task automatic stall_test();
    int sent = 0;
    int fires = 0;
    bit have = 1'b0;
    logic [31:0] hold_z = 32'd0;
    logic [31:0] sa[6];
    logic [31:0] sb[6];
    for (int i = 0; i < 6; i++) begin
      sa[i] = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
      sb[i] = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
    end
    for (int c = 0; c < 40 && (sent < 6 || c < 11); c++) begin
      @(posedge clk); #1;
      if (c < 5) begin
        if (have) check_val("stall_z_hold", mif.z, hold_z);
        else if (mif.out_valid) begin have = 1'b1; hold_z = mif.z; end
      end
      mif.out_ready = (c >= 5);
      mif.in_valid  = (sent < 6);
      if (sent < 6) begin
        mif.a = sa[sent]; mif.b = sb[sent]; mif.rmode = 2'($urandom_range(0, 3));
      end
      #1;
      if (c < 5 && sent < 6) check_val("stall_in_ready", mif.in_ready, (sent >= 3) ? 64'd0 : 64'd1);
      if (c >= 5 && c < 11 && mif.out_valid && mif.out_ready) fires++;
      if (mif.in_valid && mif.in_ready) sent++;
    end
    mif.in_valid = 1'b0;
    check_val("stall_sent", sent, 6);
    check_val("drain_consecutive", fires, 6);
  endtask

  task automatic reset_test();
    int stale = 0;
    mif.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      mif.a = 32'h40400000 + 32'(i); mif.b = 32'h3FC00000; mif.rmode = 2'd0;
      mif.in_valid = 1'b1;
    end
    @(posedge clk); #1;
    mif.in_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check_val("rst_mid_out_valid", mif.out_valid, 64'd0);
    check_val("rst_mid_z", mif.z, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (mif.out_valid) stale++;
    end
    check_val("rst_no_stale", stale, 0);
  endtask

  task automatic random_test();
    int sent = 0;
    for (int c = 0; c < 4000 && (sent < 300 || exp_q.size() != 0); c++) begin
      @(posedge clk); #1;
      mif.out_ready = ($urandom_range(0, 3) != 0);
      mif.in_valid  = (sent < 300) && ($urandom_range(0, 3) != 0);
      mif.a = rand_fp(); mif.b = rand_fp(); mif.rmode = 2'($urandom_range(0, 3));
      #1;
      if (mif.in_valid && mif.in_ready) sent++;
    end
    mif.in_valid = 1'b0;
    check_val("rand_sent", sent, 300);
  endtask

  logic [31:0] d_a [11] = '{32'h3FC00000, 32'h3F800001, 32'h3F800001, 32'h7F000000, 32'h7F000000,
                            32'hFF000000, 32'h7F800000, 32'h00400000, 32'hFF000000, 32'h00800000,
                            32'h7F800000};
  logic [31:0] d_b [11] = '{32'h40000000, 32'h3FC00000, 32'h3FC00000, 32'h7F000000, 32'h7F000000,
                            32'h7F000000, 32'h00000000, 32'hC0000000, 32'h7F000000, 32'h00800000,
                            32'hC0000000};
  logic [1:0]  d_r [11] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0};
  logic [31:0] d_z [11] = '{32'h40400000, 32'h3FC00002, 32'h3FC00001, 32'h7F800000, 32'h7F7FFFFF,
                            32'hFF7FFFFF, 32'h7FC00000, 32'h80000000, 32'hFF800000, 32'h00000000,
                            32'hFF800000};
  logic [3:0]  d_f [11] = '{4'b0000, 4'b0001, 4'b0001, 4'b0101, 4'b0101, 4'b0101, 4'b1000, 4'b0000,
                            4'b0101, 4'b0011, 4'b0000};

  initial begin
    mif.in_valid = 1'b0; mif.a = 32'd0; mif.b = 32'd0; mif.rmode = 2'd0; mif.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_out_valid", mif.out_valid, 64'd0);
    check_val("rst_z", mif.z, 64'd0);
`ifdef FPU_MUL_FLAGS_EN
    check_val("rst_flags", mif.flags, 64'd0);
`endif
    rst = 1'b0;
    #1;
    check_val("rst_in_ready", mif.in_ready, 64'd1);
    for (int i = 0; i < 11; i++) send_op(d_a[i], d_b[i], d_r[i], d_z[i], d_f[i]);
    stall_test();
    reset_test();
    random_test();
    check_val("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
